// File: rtl/geofence_pkg.sv
// geofence_pkg: shared types and constants for the geofence point feeder.
//   COORD_W - coordinate width of X and Y
//   NPTS    - points per set: one test point followed by 6 fence vertices
//   IDX_W   - width of buffer pointer/index; must be able to hold NPTS (full)
//   point_t - one {x,y} record
//   state_t - feeder FSM states
package geofence_pkg;

  localparam int COORD_W = 10;
  localparam int NPTS    = 7;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/geofence_feeder_if.sv
// geofence_feeder_if: the two streams the feeder sits between.
//   Upstream point stream: pt_valid, pt_ready, pt_x, pt_y.
//     Valid/ready: a point transfers on every rising clk edge where
//     pt_valid and pt_ready are both high. The source must hold pt_x/pt_y
//     stable while pt_valid is high and pt_ready is low; pt_ready never
//     depends combinationally on pt_valid.
//   Engine side: fence_rst, X, Y (all registered, feeder to engine) and
//     valid, is_inside (engine result strobe and value).
// master: the feeder's view. slave: the view of whatever drives the feeder.
interface geofence_feeder_if;
  import geofence_pkg::*;

  logic               pt_valid;
  logic               pt_ready;
  logic [COORD_W-1:0] pt_x;
  logic [COORD_W-1:0] pt_y;
  logic               fence_rst;
  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               valid;
  logic               is_inside;

  modport master (
    input  pt_valid, pt_x, pt_y, valid, is_inside,
    output pt_ready, fence_rst, X, Y
  );

  modport slave (
    output pt_valid, pt_x, pt_y, valid, is_inside,
    input  pt_ready, fence_rst, X, Y
  );

endinterface

// File: rtl/geofence_pt_buf.sv
// geofence_pt_buf: 7-entry register buffer holding one point set.
//   clk, reset   - clock, asynchronous active-high reset
//   wr_en        - write wr_data at entry wp and advance wp (ignored when full)
//   wr_data      - point to store
//   clear        - return wp to 0 (takes priority over a write)
//   wp, full     - write pointer and wp==NPTS flag
//   rd_en        - load rd_data from entry rd_idx; otherwise rd_data clears to 0
//   rd_idx       - entry to read
//   rd_data      - registered read data (zero when not reading)
module geofence_pt_buf
  import geofence_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  point_t           wr_data,
  input  logic             clear,
  output logic [IDX_W-1:0] wp,
  output logic             full,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output point_t           rd_data
);

  point_t mem [NPTS];

  assign full = (wp == IDX_W'(NPTS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      for (int i = 0; i < NPTS; i++) mem[i] <= '0;
    end else if (clear) begin
      wp <= '0;
    end else if (wr_en && !full) begin
      mem[wp] <= wr_data;
      wp      <= wp + IDX_W'(1);
    end
  end

  // Reading zero when idle lets the engine-facing X/Y come straight from
  // this register with no extra mux after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= rd_en ? mem[rd_idx] : '0;
  end

endmodule

// File: rtl/geofence_feeder.sv
// geofence_feeder: transmit-side driver for the geofence point protocol.
// Buffers one test point plus 6 vertices, bursts them to the engine on 7
// consecutive cycles with fence_rst low, then waits for the engine result.
// The engine samples every cycle, so holding it in reset (fence_rst) is the
// only way to keep it idle between sets.
//   clk, reset    - clock, asynchronous active-high reset
//   bus           - geofence_feeder_if.master (point stream + engine side)
//   res_valid     - one-cycle strobe per completed set
//   res_inside    - engine result, qualified by res_valid
//   res_timeout   - set ended by timeout, qualified by res_valid
//   set_cnt       - sets completed (results + timeouts), saturating
//   inside_cnt    - sets reported inside, saturating
//   busy          - high in SEND or WAIT
//   dbg_state     - current FSM state
module geofence_feeder
  import geofence_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  geofence_feeder_if.master    bus,
  output logic                 res_valid,
  output logic                 res_inside,
  output logic                 res_timeout,
  output logic [CNT_W-1:0]     set_cnt,
  output logic [CNT_W-1:0]     inside_cnt,
  output logic                 busy,
  output state_t               dbg_state
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   si, si_d;
  logic [TMO_W-1:0]   tmo, tmo_d;
  logic               fence_rst_q, fence_rst_d;
  logic               res_valid_d, res_inside_d, res_timeout_d;
  logic               set_inc, inside_inc;

  logic               pt_hs;
  logic [IDX_W-1:0]   buf_wp;
  logic               buf_full;
  logic               buf_clear;
  logic               rd_en;
  logic [IDX_W-1:0]   rd_idx;
  point_t             rd_data;
  point_t             wr_data;

  assign bus.pt_ready = !buf_full && (state != SEND);
  assign pt_hs        = bus.pt_valid && bus.pt_ready;
  assign wr_data      = '{x: bus.pt_x, y: bus.pt_y};

  geofence_pt_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pt_hs),
    .wr_data (wr_data),
    .clear   (buf_clear),
    .wp      (buf_wp),
    .full    (buf_full),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign bus.X        = rd_data.x;
  assign bus.Y        = rd_data.y;
  assign bus.fence_rst = fence_rst_q;
  assign busy         = (state == SEND) || (state == WAIT);
  assign dbg_state    = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOAD;
      si          <= '0;
      tmo         <= '0;
      fence_rst_q <= 1'b1;
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_timeout <= 1'b0;
      set_cnt     <= '0;
      inside_cnt  <= '0;
    end else begin
      state       <= state_d;
      si          <= si_d;
      tmo         <= tmo_d;
      fence_rst_q <= fence_rst_d;
      res_valid   <= res_valid_d;
      res_inside  <= res_inside_d;
      res_timeout <= res_timeout_d;
      if (set_inc && (set_cnt != '1))
        set_cnt <= set_cnt + CNT_W'(1);
      if (inside_inc && (inside_cnt != '1))
        inside_cnt <= inside_cnt + CNT_W'(1);
    end
  end

  // Every transition into SEND also issues the read of entry 0, so point 0
  // lands on X/Y in the same cycle fence_rst first reads low.
  always_comb begin
    state_d       = state;
    si_d          = si;
    tmo_d         = tmo;
    fence_rst_d   = fence_rst_q;
    rd_en         = 1'b0;
    rd_idx        = '0;
    buf_clear     = 1'b0;
    res_valid_d   = 1'b0;
    res_inside_d  = 1'b0;
    res_timeout_d = 1'b0;
    set_inc       = 1'b0;
    inside_inc    = 1'b0;

    unique case (state)
      LOAD: begin
        fence_rst_d = 1'b1;
        // A 7th point accepted this cycle counts as full.
        if (buf_full || ((buf_wp == LAST_IDX) && pt_hs)) begin
          state_d     = SEND;
          fence_rst_d = 1'b0;
          rd_en       = 1'b1;
          rd_idx      = '0;
          si_d        = '0;
        end
      end

      SEND: begin
        fence_rst_d = 1'b0;
        if (si == LAST_IDX) begin
          // Last point is on the bus; free the buffer for the next set.
          buf_clear = 1'b1;
          state_d   = WAIT;
          tmo_d     = '0;
        end else begin
          rd_en  = 1'b1;
          rd_idx = si + IDX_W'(1);
          si_d   = si + IDX_W'(1);
        end
      end

      WAIT: begin
        fence_rst_d = 1'b0;
        tmo_d       = tmo + TMO_W'(1);
        if (bus.valid) begin
          res_valid_d  = 1'b1;
          res_inside_d = bus.is_inside;
          set_inc      = 1'b1;
          inside_inc   = bus.is_inside;
          if (buf_full) begin
            // Engine is back in idle next cycle; feed it without a reset.
            state_d = SEND;
            rd_en   = 1'b1;
            rd_idx  = '0;
            si_d    = '0;
          end else begin
            state_d     = LOAD;
            fence_rst_d = 1'b1;
          end
        end else if (tmo == TMO_W'(TIMEOUT - 2)) begin
          // tmo reaches TIMEOUT-1 on this edge: the result appears exactly
          // TIMEOUT cycles after the last point was driven.
          res_valid_d   = 1'b1;
          res_timeout_d = 1'b1;
          set_inc       = 1'b1;
          state_d       = LOAD;
          fence_rst_d   = 1'b1;
        end
      end

      default: begin
        state_d     = LOAD;
        fence_rst_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_geofence_feeder.sv
// tb_geofence_feeder: directed bench for geofence_feeder with a small
// behavioural engine that counts fence_rst-low cycles and pulses valid
// eng_delay cycles after the 7th point it has seen.
module tb_geofence_feeder;
  import geofence_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        res_valid, res_inside, res_timeout, busy;
  logic [15:0] set_cnt, inside_cnt;
  state_t      dbg_state;

  geofence_feeder_if bus();

  geofence_feeder #(.TIMEOUT(64), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .res_valid   (res_valid),
    .res_inside  (res_inside),
    .res_timeout (res_timeout),
    .set_cnt     (set_cnt),
    .inside_cnt  (inside_cnt),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // engine model knobs and state
  logic eng_on, eng_inside;
  int   eng_delay, eng_cnt, rst_hi_cnt;

  int vx[6] = '{50, 150, 200, 150, 50, 0};
  int vy[6] = '{50, 50, 100, 150, 150, 100};
  logic [9:0] sx[7];
  logic [9:0] sy[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and run one step of the engine model.
  task automatic tick();
    @(negedge clk);
    bus.valid     = 1'b0;
    bus.is_inside = 1'b0;
    if (bus.fence_rst === 1'b1) begin
      eng_cnt = 0;
      rst_hi_cnt++;
    end else begin
      eng_cnt++;
      if (eng_on && (eng_cnt == 7 + eng_delay)) begin
        bus.valid     = 1'b1;
        bus.is_inside = eng_inside;
        eng_cnt       = 0;
      end
    end
  endtask

  task automatic make_set(input int tx, input int ty, input int ofs);
    sx[0] = 10'(tx);
    sy[0] = 10'(ty);
    for (int i = 0; i < 6; i++) begin
      sx[i+1] = 10'(vx[i] + ofs);
      sy[i+1] = 10'(vy[i] + ofs);
    end
  endtask

  // driver: present one point and hold it until it is accepted
  task automatic send_point(input logic [9:0] x, input logic [9:0] y);
    int n;
    n = 0;
    bus.pt_valid = 1'b1;
    bus.pt_x     = x;
    bus.pt_y     = y;
    while (bus.pt_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("pt_accept", bus.pt_ready, 1'b1);
    tick();
    bus.pt_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 7; i++) send_point(sx[i], sy[i]);
  endtask

  // Called in the first SEND cycle; returns in the cycle of the last point.
  task automatic send_set_checked();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      chk($sformatf("x_pt%0d", k), bus.X, sx[k]);
      chk($sformatf("y_pt%0d", k), bus.Y, sy[k]);
      chk($sformatf("frst_pt%0d", k), bus.fence_rst, 1'b0);
      chk($sformatf("rdy_pt%0d", k), bus.pt_ready, 1'b0);
    end
  endtask

  task automatic wait_res(input int budget, output int waited);
    waited = 0;
    while (res_valid !== 1'b1 && waited < budget) begin
      tick();
      waited++;
    end
    chk("res_wait", res_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    reset         = 1'b1;
    bus.pt_valid  = 1'b0;
    bus.pt_x      = '0;
    bus.pt_y      = '0;
    bus.valid     = 1'b0;
    bus.is_inside = 1'b0;
    eng_on        = 1'b1;
    eng_inside    = 1'b1;
    eng_delay     = 3;
    eng_cnt       = 0;
    rst_hi_cnt    = 0;

    // reset values
    #2;
    chk("rst_fence_rst", bus.fence_rst, 1'b1);
    chk("rst_x", bus.X, 0);
    chk("rst_y", bus.Y, 0);
    chk("rst_pt_ready", bus.pt_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_inside", res_inside, 1'b0);
    chk("rst_res_timeout", res_timeout, 1'b0);
    chk("rst_set_cnt", set_cnt, 0);
    chk("rst_inside_cnt", inside_cnt, 0);
    chk("rst_busy", busy, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_pt_ready", bus.pt_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // inside set: result 3 cycles after the 7th point
    make_set(100, 100, 0);
    load_all();
    send_set_checked();
    wait_res(20, w);
    chk("in_latency", w, 4);
    chk("in_res_inside", res_inside, 1'b1);
    chk("in_res_timeout", res_timeout, 1'b0);
    chk("in_set_cnt", set_cnt, 1);
    chk("in_inside_cnt", inside_cnt, 1);
    chk("in_fence_rst", bus.fence_rst, 1'b1);
    tick();
    chk("in_res_pulse", res_valid, 1'b0);

    // outside set
    eng_inside = 1'b0;
    make_set(300, 300, 0);
    load_all();
    send_set_checked();
    tick();
    tick();
    tick();
    chk("out_no_res_yet", res_valid, 1'b0);
    chk("out_frst_valid_cyc", bus.fence_rst, 1'b0);
    tick();
    chk("out_res_valid", res_valid, 1'b1);
    chk("out_res_inside", res_inside, 1'b0);
    chk("out_set_cnt", set_cnt, 2);
    chk("out_inside_cnt", inside_cnt, 1);
    chk("out_frst_after", bus.fence_rst, 1'b1);

    // timeout set, loaded with upstream gaps carrying junk data
    eng_on = 1'b0;
    make_set(10, 20, 3);
    for (int i = 0; i < 7; i++) begin
      send_point(sx[i], sy[i]);
      if (i < 6) begin
        bus.pt_x = 10'(1000 - i);
        bus.pt_y = 10'd1001;
        tick();
      end
      if (i == 5) begin
        chk("gap_not_sending", busy, 1'b0);
        chk("gap_fence_rst", bus.fence_rst, 1'b1);
      end
    end
    send_set_checked();
    wait_res(100, w);
    chk("tmo_latency", w, 64);
    chk("tmo_res_timeout", res_timeout, 1'b1);
    chk("tmo_res_inside", res_inside, 1'b0);
    chk("tmo_fence_rst", bus.fence_rst, 1'b1);
    chk("tmo_set_cnt", set_cnt, 3);
    chk("tmo_inside_cnt", inside_cnt, 1);
    tick();
    chk("tmo_res_pulse", res_valid, 1'b0);

    // valid while in LOAD is ignored
    bus.valid     = 1'b1;
    bus.is_inside = 1'b1;
    tick();
    chk("ign_res_valid", res_valid, 1'b0);
    chk("ign_set_cnt", set_cnt, 3);
    chk("ign_inside_cnt", inside_cnt, 1);

    // async reset at si=3
    eng_on     = 1'b1;
    eng_inside = 1'b1;
    eng_delay  = 3;
    make_set(500, 400, 5);
    load_all();
    tick();
    tick();
    tick();
    chk("ar_x_pt3", bus.X, sx[3]);
    reset = 1'b1;
    #1;
    chk("ar_fence_rst", bus.fence_rst, 1'b1);
    chk("ar_x", bus.X, 0);
    chk("ar_y", bus.Y, 0);
    chk("ar_set_cnt", set_cnt, 0);
    chk("ar_inside_cnt", inside_cnt, 0);
    chk("ar_pt_ready", bus.pt_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    tick();
    reset = 1'b0;

    // fresh set A after reset, then set B preloaded during A's WAIT
    eng_delay = 10;
    make_set(60, 70, 1);
    for (int i = 0; i < 6; i++) send_point(sx[i], sy[i]);
    tick();
    chk("fresh_not_sending", busy, 1'b0);
    chk("fresh_fence_rst", bus.fence_rst, 1'b1);
    send_point(sx[6], sy[6]);
    rst_hi_cnt   = 0;
    bus.pt_valid = 1'b1;
    bus.pt_x     = sx[0] + 10'd7;
    bus.pt_y     = sy[0] + 10'd7;
    send_set_checked();
    for (int i = 0; i < 7; i++) send_point(sx[i] + 10'd7, sy[i] + 10'd7);
    wait_res(30, w);
    chk("b2b_a_inside", res_inside, 1'b1);
    chk("b2b_a_set_cnt", set_cnt, 1);
    for (int i = 0; i < 7; i++) begin
      sx[i] = sx[i] + 10'd7;
      sy[i] = sy[i] + 10'd7;
    end
    send_set_checked();
    chk("b2b_no_fence_rst", rst_hi_cnt, 0);
    wait_res(30, w);
    chk("b2b_b_latency", w, 11);
    chk("b2b_b_inside", res_inside, 1'b1);
    chk("b2b_set_cnt", set_cnt, 2);
    chk("b2b_inside_cnt", inside_cnt, 2);
    chk("b2b_fence_rst_end", bus.fence_rst, 1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
Transmit-side driver for the geofence point protocol. It takes point records from an upstream valid/ready stream and buffers them in sets of 7: one test point followed by 6 fence vertices. It then bursts each set on X/Y in 7 back-to-back cycles to the geofence engine, waits for the engine's valid/is_inside, and reports one result per set. It owns the engine's reset (fence_rst), because the engine samples input unconditionally every cycle and cannot be stalled any other way.

Parameters:
COORD_W, 10, coordinate width of X and Y.
NPTS, 7, points per set (test point plus 6 vertices); fixed by protocol, not for override.
TIMEOUT, 64, maximum cycles to wait for engine valid after the last point is sent.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
pt_valid  in  1  upstream point available.
pt_ready  out  1  feeder accepts a point this cycle.
pt_x  in  COORD_W  upstream point X.
pt_y  in  COORD_W  upstream point Y.
fence_rst  out  1  registered reset to the geofence engine, active-high.
X  out  COORD_W  point X to the engine.
Y  out  COORD_W  point Y to the engine.
valid  in  1  engine result strobe (single-cycle).
is_inside  in  1  engine result, qualified by valid.
res_valid  out  1  one-cycle result strobe, one per set.
res_inside  out  1  result value, qualified by res_valid.
res_timeout  out  1  set this result was a timeout, qualified by res_valid.
set_cnt  out  CNT_W  sets completed (results plus timeouts).
inside_cnt  out  CNT_W  sets reported inside.
busy  out  1  high in SEND or WAIT.

Behaviour:
- Reset values:
  - state LOAD, fence_rst=1, X=Y=0, pt_ready=1.
  - res_valid=res_inside=res_timeout=0.
  - set_cnt=inside_cnt=0, buffer write pointer wp=0, send index si=0.
- Buffer:
  - 7 entries of {x,y}; a handshake is pt_valid&pt_ready; entry 0 holds the test point.
  - pt_ready = (wp<7) && state!=SEND.
  - Accepted points write entry wp, then wp++.
  - wp clears to 0 on the cycle the last point (si=6) is driven.
- States LOAD, SEND, WAIT:
  - LOAD: fence_rst=1, X/Y=0. Go to SEND when wp==7, including a 7th point accepted this cycle (the transition is decided on the next edge).
  - SEND: fence_rst=0 for the whole state. X/Y = buf[si], registered, so the first cycle with fence_rst low carries point 0. si steps 0..6, one per cycle, with no gaps. After si=6, go to WAIT with tmo=0.
  - WAIT: fence_rst=0, X/Y=0. tmo increments each cycle. pt_ready follows the buffer rule, so the next set may load here.
    - On valid=1: res_valid=1 and res_inside=is_inside next cycle; set_cnt++, and inside_cnt++ if is_inside.
    - If wp==7 on the valid cycle: go directly to SEND, keeping fence_rst low. Point 0 is driven in the cycle after valid, which is the cycle the engine is back in its idle and samples.
    - Otherwise go to LOAD, with fence_rst asserted in the cycle after valid.
  - Timeout: if tmo reaches TIMEOUT-1 without valid, res_valid=1, res_timeout=1, res_inside=0, set_cnt++, go to LOAD (fence_rst=1).
  - valid outside WAIT is ignored.
- Counters saturate at all-ones.
- Async reset mid-SEND or mid-WAIT: immediately return to reset values. The partial set and buffer contents are discarded. fence_rst goes high asynchronously via its reset value.
- No combinational path from the pt_* inputs to X/Y or fence_rst. Every engine-facing output is registered.

Decomposition:
- Package geofence_pkg: COORD_W, NPTS, the point struct typedef {x,y}, and the state enum {LOAD, SEND, WAIT}.
- Sub-module geofence_pt_buf: the 7-entry register buffer, with write port, wp/full flag, clear, and registered read by index.
- FSM, timeout and counters stay in geofence_feeder.

Test Plan:
- Inside case:
  - Stimulus: stream test (100,100) and vertices (50,50),(150,50),(200,100),(150,150),(50,150),(0,100) into a behavioural engine model that returns is_inside=1 three cycles after the 7th point.
  - Required: fence_rst falls with X/Y=(100,100), the 7 points appear on consecutive cycles, then res_valid with res_inside=1, set_cnt=1, inside_cnt=1.
- Outside case: same vertices with test (300,300), model returns 0 -> res_inside=0, inside_cnt unchanged, fence_rst re-asserted the cycle after valid (next set not yet loaded).
- Back-to-back sets:
  - Stimulus: preload the second set during WAIT (pt_valid held high).
  - Required: the second set's point 0 is driven the cycle immediately after valid, fence_rst never rises, pt_ready=0 throughout SEND; after two sets set_cnt=2.
- Timeout: model never asserts valid -> exactly 64 cycles after the last point, res_valid=1 and res_timeout=1, fence_rst=1, set_cnt increments, inside_cnt unchanged.
- Upstream gaps: pt_valid toggled 1-0-1 while loading -> only handshaked points are stored, and SEND starts only after the 7th accepted point.
- Async reset asserted at si=3: fence_rst=1, X/Y=0, counters 0 and pt_ready=1 with no clock. After release, a fresh 7-point set is required before SEND.
